// File: rtl/fe_hazard_ctrl_pkg.sv
// fe_hazard_ctrl_pkg: shared PC-select and controller state encodings for the hazard sequencer.
package fe_hazard_ctrl_pkg;
  typedef enum logic [1:0] {PCSEL_NEXT = 2'b00, PCSEL_HOLD = 2'b01, PCSEL_TARGET = 2'b10} pc_sel_e;
  typedef enum logic [1:0] {HZ_RUN = 2'b00, HZ_REDIRECT = 2'b01, HZ_HALT = 2'b10} hz_state_e;
  localparam int FROM_HZ_TO_FE_WIDTH = 4;
  localparam int FROM_HZ_TO_DE_WIDTH = 2;
endpackage

// File: rtl/fe_hazard_perf.sv
// fe_hazard_perf: hold/flush/redirect event counters, built only with FE_HAZARD_PERF_EN.
`ifdef FE_HAZARD_PERF_EN
module fe_hazard_perf (
  input  logic        clk,
  input  logic        reset,
  input  logic        fe_hold,
  input  logic        fe_flush,
  input  logic        redirect,
  output logic [31:0] perf_stall_cyc,
  output logic [31:0] perf_flush_cyc,
  output logic [31:0] perf_redirects
);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      perf_stall_cyc <= '0;
      perf_flush_cyc <= '0;
      perf_redirects <= '0;
    end else begin
      perf_stall_cyc <= perf_stall_cyc + 32'(fe_hold);
      perf_flush_cyc <= perf_flush_cyc + 32'(fe_flush);
      perf_redirects <= perf_redirects + 32'(redirect);
    end
endmodule
`endif

// File: rtl/fe_hazard_ctrl.sv
// fe_hazard_ctrl: stall/flush/redirect sequencer for FE and DE latches; FE_HAZARD_PERF_EN adds perf counters.
module fe_hazard_ctrl
  import fe_hazard_ctrl_pkg::*;
#(
  parameter int DBITS         = 32,
  parameter int FLUSH_CYCLES  = 1,
  parameter int STALL_TIMEOUT = 255,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             de_stall_req,
  input  logic             mem_stall_req,
  input  logic             agex_br_taken,
  input  logic [DBITS-1:0] agex_br_target,
  input  logic             wb_halt_req,
  input  logic             resume,
  output logic [1:0]       fe_pc_sel,
  output logic [DBITS-1:0] fe_pc_target,
  output logic             fe_hold,
  output logic             fe_flush,
  output logic             de_hold,
  output logic             de_bubble,
  output logic             halted,
  output logic             stall_timeout
`ifdef FE_HAZARD_PERF_EN
  ,
  output logic [31:0]      perf_stall_cyc,
  output logic [31:0]      perf_flush_cyc,
  output logic [31:0]      perf_redirects
`endif
);
  hz_state_e        state, state_nx;
  logic [3:0]       fcnt, fcnt_nx;
  logic [CNT_W-1:0] scnt;
  logic             to_q, hit;
  pc_sel_e          sel;
  logic             fh, ff, dh, db;
  always_comb begin
    state_nx = state;
    fcnt_nx  = fcnt;
    sel      = PCSEL_NEXT;
    {fh, ff, dh, db} = '0;
    case (state)
      HZ_HALT: begin
        sel = PCSEL_HOLD;
        {ff, db} = 2'b11;
        state_nx = resume ? HZ_RUN : HZ_HALT;
      end
      HZ_REDIRECT: begin
        ff  = 1'b1;
        sel = mem_stall_req ? PCSEL_HOLD : PCSEL_NEXT;
        if (wb_halt_req) state_nx = HZ_HALT;
        else if (!mem_stall_req) begin
          fcnt_nx  = fcnt - 4'd1;
          state_nx = (fcnt == 4'd1) ? HZ_RUN : HZ_REDIRECT;
        end
      end
      default:
        if (wb_halt_req) begin
          sel = PCSEL_HOLD;
          {ff, db} = 2'b11;
          state_nx = HZ_HALT;
        end else if (mem_stall_req) begin
          sel = PCSEL_HOLD;
          {fh, dh} = 2'b11;
        end else if (agex_br_taken) begin
          sel = PCSEL_TARGET;
          {ff, db} = 2'b11;
          if (FLUSH_CYCLES > 1) begin
            state_nx = HZ_REDIRECT;
            fcnt_nx  = 4'(FLUSH_CYCLES - 1);
          end
        end else if (de_stall_req) begin
          sel = PCSEL_HOLD;
          {fh, dh, db} = 3'b111;
        end
    endcase
  end
  // Outputs are forced idle while reset is held, not just after the state register clears.
  assign fe_pc_sel     = reset ? sel : PCSEL_NEXT;
  assign fe_pc_target  = (fe_pc_sel == PCSEL_TARGET) ? agex_br_target : '0;
  assign fe_hold       = reset & fh;
  assign fe_flush      = reset & ff;
  assign de_hold       = reset & dh;
  assign de_bubble     = reset & db;
  assign halted        = reset & (state == HZ_HALT);
  assign hit           = fe_hold && (scnt >= CNT_W'(STALL_TIMEOUT - 1));
  assign stall_timeout = to_q | hit;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= HZ_RUN;
      fcnt  <= '0;
      scnt  <= '0;
      to_q  <= 1'b0;
    end else begin
      state <= state_nx;
      fcnt  <= fcnt_nx;
      scnt  <= fe_hold ? (&scnt ? scnt : scnt + 1'b1) : '0;
      to_q  <= to_q | hit;
    end
`ifdef FE_HAZARD_PERF_EN
  fe_hazard_perf u_perf (
    .clk            (clk),
    .reset          (reset),
    .fe_hold        (fe_hold),
    .fe_flush       (fe_flush),
    .redirect       (fe_pc_sel == PCSEL_TARGET),
    .perf_stall_cyc (perf_stall_cyc),
    .perf_flush_cyc (perf_flush_cyc),
    .perf_redirects (perf_redirects)
  );
`endif
endmodule
